led_pulse_stretcher: RTL

//  Human-facing output side of the front-panel I/O: turns single-cycle status strobes
//  (key accepted, UART byte, reset seen, ...) into LED blinks long enough to see.
//  Per channel: ON phase, then forced OFF gap, so back-to-back events stay distinct.

---
 rtl/led_pulse_stretcher_pkg.sv | 28 ++
 rtl/led_stretch_ch.sv | 114 +++++++++++
 rtl/led_pulse_stretcher.sv | 46 ++++
 3 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } stretch_state_t;

    // Ceiling log2 for sizing counters at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int width_for(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: OFF/ON/GAP sequencer with a saturating blink queue
// and a sticky overflow flag.
module led_stretch_ch
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 2500000,
    parameter int GAP_CYCLES = 1250000,
    parameter int PEND_MAX   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ev,
    input  logic ovf_clr,
    output logic led,
    output logic busy,
    output logic ovf
);

    localparam int CW = width_for((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES);
    localparam int PW = width_for(PEND_MAX + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);

    stretch_state_t state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [PW-1:0]  pend, pend_next;
    logic           ovf_next;
    logic           last_gap;
    logic           take_direct;
    logic           deq;
    logic           enq;
    logic           drop;

    // State, counter, queue and registered outputs; led/busy follow the next state
    // so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            cnt   <= '0;
            pend  <= '0;
            ovf   <= 1'b0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
            ovf   <= ovf_next;
            led   <= (state_next == ST_ON);
            busy  <= (state_next != ST_OFF);
        end
    end

    // Next-state sequencing plus queue bookkeeping; an event that starts a blink
    // directly is never queued, and a dequeue cancels a same-cycle enqueue.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pend_next   = pend;
        ovf_next    = ovf;
        last_gap    = (state == ST_GAP) && (cnt == GAP_LAST);
        deq         = last_gap && (pend != '0);
        take_direct = ev && (((state == ST_OFF)) || (last_gap && (pend == '0)));
        enq         = ev && !take_direct;
        drop        = enq && !deq && (pend == PEND_TOP);

        case (state)
            ST_OFF: begin
                if (ev) begin
                    state_next = ST_ON;
                    cnt_next   = '0;
                end
            end
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (last_gap) begin
                    cnt_next = '0;
                    if (pend != '0 || ev) begin
                        state_next = ST_ON;
                    end else begin
                        state_next = ST_OFF;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = '0;
            end
        endcase

        if (deq && !enq) begin
            pend_next = pend - 1'b1;
        end else if (enq && !deq && !drop) begin
            pend_next = pend + 1'b1;
        end

        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Front-panel LED pulse stretcher: independent per-channel blink sequencers,
// with pin polarity applied at the output.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int ON_CYCLES       = 2500000,
    parameter int GAP_CYCLES      = 1250000,
    parameter int PEND_MAX        = 3,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ev_i,
    input  logic [CHANNELS-1:0] ovf_clr_i,
    output logic [CHANNELS-1:0] led_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] ovf_o
);

    if (CHANNELS < 1)   begin : g_bad_channels $error("CHANNELS must be >= 1");   end
    if (ON_CYCLES < 1)  begin : g_bad_on       $error("ON_CYCLES must be >= 1");  end
    if (GAP_CYCLES < 1) begin : g_bad_gap      $error("GAP_CYCLES must be >= 1"); end
    if (PEND_MAX < 1)   begin : g_bad_pend     $error("PEND_MAX must be >= 1");   end

    logic [CHANNELS-1:0] led_raw;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_stretch_ch #(
            .ON_CYCLES  (ON_CYCLES),
            .GAP_CYCLES (GAP_CYCLES),
            .PEND_MAX   (PEND_MAX)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ev      (ev_i[i]),
            .ovf_clr (ovf_clr_i[i]),
            .led     (led_raw[i]),
            .busy    (busy_o[i]),
            .ovf     (ovf_o[i])
        );
    end

    assign led_o = LED_ACTIVE_HIGH ? led_raw : ~led_raw;

endmodule
